regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
Next-generation integer register file for the RV32I core, parametrised in data width and register count. It adds a clocked write port with an asynchronous active-low reset and optional same-cycle write-to-read bypass. It also adds a per-register busy scoreboard that tracks in-flight destination registers and raises a stall for the decode stage. It sits between decode (read and issue side) and writeback (write side).

Parameters:
XLEN, 32, register data width in bits
ADDR_W, 5, register index width; NREGS = 2**ADDR_W
BYPASS, 1, 1 = the writeback value is forwarded to read ports in the same cycle; 0 = reads return stored value only
ZERO_REG, 1, 1 = register 0 is hardwired to zero and is never busy

Ports:
CLK  input  1  clock, all state updates on rising edge
RESET_N  input  1  asynchronous active-low reset
R1  input  ADDR_W  read port 1 index
R2  input  ADDR_W  read port 2 index
R1_data  output  XLEN  read port 1 data
R2_data  output  XLEN  read port 2 data
RD  input  ADDR_W  writeback destination index
RD_DATA  input  XLEN  writeback data
reg_write_enable  input  1  writeback strobe
ISSUE_RD  input  ADDR_W  destination of the instruction being issued
issue_enable  input  1  marks ISSUE_RD busy
R1_busy  output  1  R1 has a pending, un-bypassed producer
R2_busy  output  1  R2 has a pending, un-bypassed producer
stall  output  1  R1_busy | R2_busy
busy_count  output  ADDR_W+1  number of busy registers

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on RESET_N. While RESET_N=0, all registers are 0 and all busy bits are 0. As a result, R1_data=R2_data=0, R1_busy=R2_busy=stall=0 and busy_count=0, regardless of the clock.
- Reset deasserting mid-operation: any write or issue in flight is lost and no partial state remains.
- Write: on the rising CLK edge with reg_write_enable=1, regs[RD] <= RD_DATA. With ZERO_REG=1, a write with RD=0 is ignored.
- Read: combinational, zero-cycle latency. Rn_data = regs[Rn], with these overrides:
  - With BYPASS=1, if reg_write_enable=1, RD=Rn and RD is writable, then Rn_data = RD_DATA.
  - With ZERO_REG=1, Rn=0 always gives 0.
- Scoreboard set: on the CLK edge with issue_enable=1, busy[ISSUE_RD] <= 1. Ignored when ISSUE_RD=0 and ZERO_REG=1.
- Scoreboard clear: on the CLK edge with reg_write_enable=1, busy[RD] <= 0.
- Simultaneous set and clear on the same index: set wins, so busy stays 1 (a new producer supersedes the completing one). Different indices are updated independently.
- Issue to an already-busy register: busy stays 1, with no count change and no error.
- Write to a non-busy register: the data is written and busy stays 0.
- Busy outputs: Rn_busy = busy[Rn] & ~(BYPASS & reg_write_enable & RD==Rn). A register being written back this cycle is not reported busy when bypass is enabled. Rn_busy is 0 for Rn=0 when ZERO_REG=1.
- stall = R1_busy | R2_busy, combinational.
- busy_count: a registered popcount of the busy bits, updated on the same edge as the busy bits. Per edge it changes by +1, -1 or 0. It never exceeds NREGS-ZERO_REG and never underflows.
- Timing: there are no combinational paths from ISSUE_RD or issue_enable to any output. The read path may depend combinationally on RD, RD_DATA and reg_write_enable only when BYPASS=1.

Test Plan:
- Reset: drive RESET_N=0 with no clock edges → all outputs 0. Release, then read R1=7, R2=31 → 0, 0, busy=0, busy_count=0.
- Write then read: write RD=1, RD_DATA=5, then RD=2, RD_DATA=10 on consecutive edges. Then read R1=1, R2=2 → 5, 10. Write RD=0, RD_DATA=0xFFFFFFFF, then read R1=0 → 0.
- Bypass: in the same cycle drive reg_write_enable=1, RD=3, RD_DATA=0xDEADBEEF and R1=3 → R1_data=0xDEADBEEF before the edge. With BYPASS=0, the same stimulus gives the old value 0.
- Scoreboard: issue ISSUE_RD=4, then read R2=4 → R2_busy=1, stall=1, busy_count=1. Write back RD=4, RD_DATA=9 → R2_busy=0 in that cycle (BYPASS=1), R2_data=9; after the edge, busy_count=0.
- Simultaneous set and clear: with busy[5]=1, issue ISSUE_RD=5 and write RD=5 on the same edge → busy[5] stays 1, data updated, busy_count unchanged. Issue ISSUE_RD=0 → no busy bit set, count unchanged.
- Reset mid-operation: with busy[4]=1, busy[6]=1, regs[1]=5, pulse RESET_N=0 between edges → outputs go to 0 immediately (async), busy_count=0, and regs[1] reads 0 after release.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Integer register file with a write-back port, optional same-cycle write-to-read
// bypass, and a per-register busy scoreboard that stalls decode on pending producers.
module regfile_scoreboard #(
   parameter int XLEN     = 32,
   parameter int ADDR_W   = 5,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic [ADDR_W-1:0] R1,
   input  logic [ADDR_W-1:0] R2,
   output logic [XLEN-1:0]   R1_data,
   output logic [XLEN-1:0]   R2_data,
   input  logic [ADDR_W-1:0] RD,
   input  logic [XLEN-1:0]   RD_DATA,
   input  logic              reg_write_enable,
   input  logic [ADDR_W-1:0] ISSUE_RD,
   input  logic              issue_enable,
   output logic              R1_busy,
   output logic              R2_busy,
   output logic              stall,
   output logic [ADDR_W:0]   busy_count
);

   localparam int NREGS = 2 ** ADDR_W;

   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] busy_nxt;
   logic [ADDR_W:0]  busy_cnt_q;
   logic [ADDR_W:0]  busy_cnt_nxt;

   logic rd_writable;
   logic issue_settable;
   logic r1_zero;
   logic r2_zero;
   logic r1_bypass;
   logic r2_bypass;

   // Index 0 is neither writable nor trackable when it is the hardwired zero register.
   assign rd_writable    = reg_write_enable && !((ZERO_REG != 0) && (RD == '0));
   assign issue_settable = issue_enable && !((ZERO_REG != 0) && (ISSUE_RD == '0));

   assign r1_zero   = (ZERO_REG != 0) && (R1 == '0);
   assign r2_zero   = (ZERO_REG != 0) && (R2 == '0);
   assign r1_bypass = (BYPASS != 0) && rd_writable && (RD == R1);
   assign r2_bypass = (BYPASS != 0) && rd_writable && (RD == R2);

   // Clear first, then set: an issue to the register completing this cycle keeps it busy.
   always_comb begin
      busy_nxt = busy;
      if (reg_write_enable) begin
         busy_nxt[RD] = 1'b0;
      end
      if (issue_settable) begin
         busy_nxt[ISSUE_RD] = 1'b1;
      end
   end

   always_comb begin
      busy_cnt_nxt = '0;
      for (int i = 0; i < NREGS; i++) begin
         busy_cnt_nxt = busy_cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (rd_writable) begin
         regs[RD] <= RD_DATA;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         busy       <= '0;
         busy_cnt_q <= '0;
      end else begin
         busy       <= busy_nxt;
         busy_cnt_q <= busy_cnt_nxt;
      end
   end

   always_comb begin
      R1_data = regs[R1];
      if (r1_bypass) begin
         R1_data = RD_DATA;
      end
      if (r1_zero) begin
         R1_data = '0;
      end
   end

   always_comb begin
      R2_data = regs[R2];
      if (r2_bypass) begin
         R2_data = RD_DATA;
      end
      if (r2_zero) begin
         R2_data = '0;
      end
   end

   // A producer completing this cycle is forwarded, so it no longer blocks the reader.
   assign R1_busy    = busy[R1] && !r1_bypass && !r1_zero;
   assign R2_busy    = busy[R2] && !r2_bypass && !r2_zero;
   assign stall      = R1_busy || R2_busy;
   assign busy_count = busy_cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: a bypassing instance and a non-bypassing
// instance share all inputs so both read behaviours are checked side by side.
module tb_regfile_scoreboard;

   logic        clk;
   logic        rst_n;
   logic [4:0]  r1, r2, rd, issue_rd;
   logic [31:0] rd_data;
   logic        we, issue_en;

   logic [31:0] r1_data, r2_data, nb_r1_data, nb_r2_data;
   logic        r1_busy, r2_busy, stall, nb_r1_busy, nb_r2_busy, nb_stall;
   logic [5:0]  busy_count, nb_busy_count;

   int compared;
   int mismatched;

   regfile_scoreboard dut (
      .CLK(clk), .RESET_N(rst_n), .R1(r1), .R2(r2), .R1_data(r1_data), .R2_data(r2_data),
      .RD(rd), .RD_DATA(rd_data), .reg_write_enable(we), .ISSUE_RD(issue_rd),
      .issue_enable(issue_en), .R1_busy(r1_busy), .R2_busy(r2_busy), .stall(stall),
      .busy_count(busy_count)
   );

   regfile_scoreboard #(.BYPASS(0)) dut_nb (
      .CLK(clk), .RESET_N(rst_n), .R1(r1), .R2(r2), .R1_data(nb_r1_data), .R2_data(nb_r2_data),
      .RD(rd), .RD_DATA(rd_data), .reg_write_enable(we), .ISSUE_RD(issue_rd),
      .issue_enable(issue_en), .R1_busy(nb_r1_busy), .R2_busy(nb_r2_busy), .stall(nb_stall),
      .busy_count(nb_busy_count)
   );

   // Clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      rst_n = 1'b1; r1 = 5'd7; r2 = 5'd31; rd = '0; rd_data = '0;
      we = 1'b0; issue_rd = '0; issue_en = 1'b0;

      // Reset asserted before any clock edge
      #1 rst_n = 1'b0;
      #1;
      check("rst_r1_data", r1_data, 32'd0);
      check("rst_r2_data", r2_data, 32'd0);
      check("rst_stall", {31'd0, stall}, 32'd0);
      check("rst_busy_count", {26'd0, busy_count}, 32'd0);
      #1 rst_n = 1'b1;
      tick();
      check("post_rst_r1_data", r1_data, 32'd0);
      check("post_rst_r2_data", r2_data, 32'd0);
      check("post_rst_r1_busy", {31'd0, r1_busy}, 32'd0);
      check("post_rst_busy_count", {26'd0, busy_count}, 32'd0);

      // Write then read
      we = 1'b1; rd = 5'd1; rd_data = 32'd5;
      tick();
      rd = 5'd2; rd_data = 32'd10;
      tick();
      we = 1'b0; r1 = 5'd1; r2 = 5'd2;
      #1;
      check("read_r1", r1_data, 32'd5);
      check("read_r2", r2_data, 32'd10);
      check("nb_read_r2", nb_r2_data, 32'd10);
      we = 1'b1; rd = 5'd0; rd_data = 32'hFFFF_FFFF; r1 = 5'd0;
      #1;
      check("zero_bypass_r1", r1_data, 32'd0);
      tick();
      we = 1'b0;
      #1;
      check("zero_read_r1", r1_data, 32'd0);
      check("zero_read_nb_r1", nb_r1_data, 32'd0);

      // Same-cycle bypass
      we = 1'b1; rd = 5'd3; rd_data = 32'hDEAD_BEEF; r1 = 5'd3;
      #1;
      check("bypass_r1", r1_data, 32'hDEAD_BEEF);
      check("nobypass_r1", nb_r1_data, 32'd0);
      tick();
      we = 1'b0;
      #1;
      check("stored_r1", r1_data, 32'hDEAD_BEEF);
      check("nb_stored_r1", nb_r1_data, 32'hDEAD_BEEF);

      // Scoreboard set and bypassed clear
      issue_en = 1'b1; issue_rd = 5'd4; r2 = 5'd4;
      #1;
      check("issue_no_comb_busy", {31'd0, r2_busy}, 32'd0);
      tick();
      issue_en = 1'b0;
      #1;
      check("sb_r2_busy", {31'd0, r2_busy}, 32'd1);
      check("sb_stall", {31'd0, stall}, 32'd1);
      check("sb_count", {26'd0, busy_count}, 32'd1);
      we = 1'b1; rd = 5'd4; rd_data = 32'd9;
      #1;
      check("wb_r2_busy", {31'd0, r2_busy}, 32'd0);
      check("wb_stall", {31'd0, stall}, 32'd0);
      check("wb_r2_data", r2_data, 32'd9);
      check("nb_wb_r2_busy", {31'd0, nb_r2_busy}, 32'd1);
      check("nb_wb_r2_data", nb_r2_data, 32'd0);
      tick();
      we = 1'b0;
      #1;
      check("wb_count", {26'd0, busy_count}, 32'd0);
      check("wb_stored_r2", r2_data, 32'd9);

      // Simultaneous set and clear on the same index
      issue_en = 1'b1; issue_rd = 5'd5;
      tick();
      check("set5_count", {26'd0, busy_count}, 32'd1);
      we = 1'b1; rd = 5'd5; rd_data = 32'h55;
      tick();
      we = 1'b0; issue_en = 1'b0; r1 = 5'd5;
      #1;
      check("setclr_busy", {31'd0, r1_busy}, 32'd1);
      check("setclr_data", r1_data, 32'h55);
      check("setclr_count", {26'd0, busy_count}, 32'd1);

      // Issue to register 0 and re-issue to a busy register
      issue_en = 1'b1; issue_rd = 5'd0;
      tick();
      r1 = 5'd0;
      #1;
      check("issue0_count", {26'd0, busy_count}, 32'd1);
      check("issue0_busy", {31'd0, r1_busy}, 32'd0);
      issue_rd = 5'd5;
      tick();
      check("reissue_count", {26'd0, busy_count}, 32'd1);

      // Set and clear on different indices
      issue_rd = 5'd6; we = 1'b1; rd = 5'd5; rd_data = 32'h66;
      tick();
      issue_en = 1'b0; we = 1'b0; r1 = 5'd5; r2 = 5'd6;
      #1;
      check("diff_count", {26'd0, busy_count}, 32'd1);
      check("diff_r1_busy", {31'd0, r1_busy}, 32'd0);
      check("diff_r2_busy", {31'd0, r2_busy}, 32'd1);

      // Reset mid-operation
      issue_en = 1'b1; issue_rd = 5'd4;
      tick();
      issue_en = 1'b0; r1 = 5'd4; r2 = 5'd6;
      #1;
      check("pre_rst_count", {26'd0, busy_count}, 32'd2);
      check("pre_rst_stall", {31'd0, stall}, 32'd1);
      r1 = 5'd1;
      #1;
      check("pre_rst_reg1", r1_data, 32'd5);
      rst_n = 1'b0;
      #1;
      check("mid_rst_reg1", r1_data, 32'd0);
      check("mid_rst_r2_busy", {31'd0, r2_busy}, 32'd0);
      check("mid_rst_count", {26'd0, busy_count}, 32'd0);
      #1 rst_n = 1'b1;
      tick();
      check("after_rst_reg1", r1_data, 32'd0);
      check("after_rst_count", {26'd0, busy_count}, 32'd0);
      check("after_rst_stall", {31'd0, stall}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
